// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter with a per-transaction direction bit and
// valid/ready flow control on both sides. Gray-to-binary is resolved MSB-first,
// one chunk of bits per stage. Each stage holds one word: resolved binary bits
// above the current chunk and still-unresolved Gray bits below it.
// Optional macro GRAY_CODEC_SEQ_CHECK_EN adds a sticky single-bit-step checker
// on accepted Gray (mode 1) inputs; without it seq_err is tied low.
module gray_codec_pipe #(
  parameter int CODE_WIDTH = 4,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_WIDTH-1:0] in_code,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CODE_WIDTH-1:0] out_code,
  output logic                  out_mode,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  seq_err
);

  localparam int W = CODE_WIDTH;
  localparam int C = (W + STAGES - 1) / STAGES;

  logic [STAGES-1:0]        vld_p;
  logic [STAGES-1:0]        mode_p;
  logic [STAGES-1:0][W-1:0] res_p;
  logic [STAGES-1:0]        adv;
  logic [STAGES-1:0]        vld_d;
  logic [STAGES-1:0]        mode_d;
  logic [STAGES-1:0][W-1:0] res_d;

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Resolve the chunk owned by 'stage' in place; bits above it are already
  // binary, so the running XOR is simply the previous resolved bit.
  function automatic logic [W-1:0] gray2bin_chunk(input logic [W-1:0] word,
                                                  input int stage);
    logic [W-1:0] r;
    logic         acc;
    int           hi;
    int           lo;
    r   = word;
    acc = 1'b0;
    hi  = W - 1 - stage * C;
    lo  = W - (stage + 1) * C;
    if (lo < 0) lo = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i <= hi && i >= lo) r[i] = acc ^ r[i];
      acc = r[i];
    end
    return r;
  endfunction

  // A stage may move when it or any stage downstream of it is empty, or the
  // sink is taking the output; written without feedback through adv itself.
  always_comb begin
    adv = '0;
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = out_ready;
      for (int t = s; t < STAGES; t++) begin
        if (!vld_p[t]) adv[s] = 1'b1;
      end
    end
  end

  assign in_ready = adv[0];

  // Next contents of every stage: stage 0 from the input port, others from
  // the stage above with that stage's chunk of Gray bits resolved.
  always_comb begin
    vld_d     = '0;
    mode_d    = '0;
    res_d     = '0;
    vld_d[0]  = in_valid;
    mode_d[0] = in_mode;
    res_d[0]  = in_mode ? gray2bin_chunk(in_code, 0) : bin2gray(in_code);
    for (int s = 1; s < STAGES; s++) begin
      vld_d[s]  = vld_p[s-1];
      mode_d[s] = mode_p[s-1];
      res_d[s]  = mode_p[s-1] ? gray2bin_chunk(res_p[s-1], s) : res_p[s-1];
    end
  end

  // Pipeline registers p0..p(STAGES-1); data only loads with a valid word.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      vld_p  <= '0;
      mode_p <= '0;
      res_p  <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          vld_p[s] <= vld_d[s];
          if (vld_d[s]) begin
            mode_p[s] <= mode_d[s];
            res_p[s]  <= res_d[s];
          end
        end
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_code  = res_p[STAGES-1];
  assign out_mode  = mode_p[STAGES-1];

  // Completed output handshakes, wrapping naturally at the counter width.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

`ifdef GRAY_CODEC_SEQ_CHECK_EN
  logic [W-1:0] prev_gray;
  logic         have_prev;
  logic         seq_err_q;

  // Track the last accepted Gray input; flag any step that is not one bit.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
      seq_err_q <= 1'b0;
    end else if (in_valid && in_ready && in_mode) begin
      prev_gray <= in_code;
      have_prev <= 1'b1;
      if (have_prev && ($countones(prev_gray ^ in_code) != 1)) seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
Parametrised, pipelined binary/Gray code converter with a per-transaction mode bit. It supports both directions: binary-to-Gray and Gray-to-binary. It uses a valid/ready handshake with full backpressure on both sides. It is the successor to the single-direction bin2gray block and sits on clock-domain-crossing pointer paths and encoder datapaths.

Parameters:
CODE_WIDTH, 4, code width in bits; legal range 2..32.
STAGES, 2, pipeline depth and fixed latency in cycles; legal range 1..CODE_WIDTH.
CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
clk  input  1  clock; all logic is rising-edge triggered.
rstn  input  1  reset; asynchronous, active-high.
in_valid  input  1  input transaction present.
in_ready  output  1  block can accept an input this cycle.
in_code  input  CODE_WIDTH  code to convert.
in_mode  input  1  conversion direction: 0 = binary-to-Gray, 1 = Gray-to-binary.
out_valid  output  1  output transaction present.
out_ready  input  1  downstream accepts the output.
out_code  output  CODE_WIDTH  converted code.
out_mode  output  1  mode bit carried with the transaction.
xfer_cnt  output  CNT_WIDTH  count of completed output handshakes; wraps modulo 2^CNT_WIDTH.
seq_err  output  1  sticky sequence error; see Optional Feature.

Behaviour:
- Reset (rstn=1, asynchronous assert, synchronous release):
  - all stage valid bits = 0, so out_valid = 0
  - out_code = 0, out_mode = 0
  - xfer_cnt = 0, seq_err = 0
  - in_ready = 1 from the first clock edge after release.
- Reset mid-operation discards every in-flight transaction. No output is produced for those transactions.
- Handshakes:
  - input accepted on a clk edge where in_valid & in_ready
  - output consumed on a clk edge where out_valid & out_ready
  - in_valid must not depend on in_ready; out_ready must not depend on out_valid.
- Pipeline:
  - STAGES register stages, v[0..STAGES-1], each with a valid bit, code, partial result and mode.
  - Stage s advances when v[s]=0 or stage s+1 advances. The last stage advances when out_ready=1 or it is empty.
  - in_ready = ~v[0] | adv[0], computed combinationally (bubble-collapsing, no skid buffer).
- Throughput and latency:
  - one transaction per cycle when out_ready is held at 1
  - latency is exactly STAGES cycles from the accept edge to out_valid=1 with no backpressure.
- Binary-to-Gray (mode 0): g = b ^ (b >> 1), computed in stage 0 and carried unchanged through the later stages.
- Gray-to-binary (mode 1):
  - b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - Bits are resolved MSB-first in chunks of C = ceil(CODE_WIDTH/STAGES). Stage s resolves bits W-1-s*C down to max(0, W-(s+1)*C).
  - Each stage uses the carried running XOR from the previous stage.
  - When STAGES > ceil(W/C), the surplus trailing stages pass data through unchanged.
- Mixed modes in flight are legal. Each transaction uses its own mode bit.
- Full pipeline: with out_ready=0, exactly STAGES inputs are accepted; in_ready then drops to 0.
- Simultaneous accept and drain on a full pipeline: both handshakes complete in the same cycle.
- xfer_cnt increments by 1 on every output handshake and wraps from 2^CNT_WIDTH-1 to 0.
- out_code and out_mode hold stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro GRAY_CODEC_SEQ_CHECK_EN.
- Defined:
  - The block keeps the last accepted Gray input and a "have previous" flag; the flag clears on reset.
  - The check applies to each accepted mode-1 input after the first since reset. seq_err is set if the Hamming distance from the previous mode-1 input is not exactly 1.
  - seq_err is set on the accept edge and is sticky until reset.
  - Mode-0 inputs do not affect the stored value or the check.
- Not defined: seq_err is tied to 0 and no check logic is present.

Test Plan:
Defaults W=4, STAGES=2 unless stated.
1. Reset release, then mode 0, inputs 0..15 back-to-back, out_ready=1 -> outputs 0000,0001,0011,0010,...,1000. First out_valid is exactly 2 cycles after the first accept; xfer_cnt=16.
2. Mode 1, inputs 1101, 1000, 0111 -> outputs 1001, 1111, 0101; out_mode=1 on each.
3. Hold out_ready=0, drive in_valid=1 continuously -> exactly 2 accepts, then in_ready=0. Raise out_ready -> one output per cycle, with in_ready=1 in the same cycle. No loss or duplication.
4. Alternate modes (0:0101, 1:0111, 0:1001) with random out_ready -> outputs 0111, 0101, 1101, in order and with matching modes.
5. Assert rstn mid-stream with 2 transactions in flight -> out_valid=0 immediately; no stale outputs after release; xfer_cnt=0.
6. With GRAY_CODEC_SEQ_CHECK_EN, mode 1 inputs 0000, 0001, 0011, 0000 -> seq_err rises on the 4th accept and stays 1 until reset. Repeat with STAGES=1 and STAGES=4, W=8; the scenario 1 sweep over 0..255 matches the reference model.
